// File: rtl/alu_dec_stage.sv
// RV32I integer decode stage: one registered skid-free entry that turns an
// OP / OP-IMM / LUI / AUIPC instruction into ALU operands and control.
module alu_dec_stage #(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [DATA_W-1:0]   pc,
  input  logic [DATA_W-1:0]   rs1_val,
  input  logic [DATA_W-1:0]   rs2_val,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_src_a,
  output logic [DATA_W-1:0]   out_src_b,
  output logic [ALU_OP_W-1:0] out_op,
  output logic                out_alt,
  output logic [4:0]          out_rd,
  output logic                out_we,
  output logic                out_illegal,
  output logic [CNT_W-1:0]    dec_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]          opcode_s;
  logic [2:0]          funct3_s;
  logic [6:0]          funct7_s;
  logic [4:0]          rd_s;
  logic [DATA_W-1:0]   imm_i_s;
  logic [DATA_W-1:0]   imm_u_s;
  logic                accept_s;

  logic [DATA_W-1:0]   src_a_s;
  logic [DATA_W-1:0]   src_b_s;
  logic [2:0]          op_s;
  logic                alt_s;
  logic                illegal_s;
  logic                we_s;

  logic                valid_r;
  logic [DATA_W-1:0]   src_a_r;
  logic [DATA_W-1:0]   src_b_r;
  logic [ALU_OP_W-1:0] op_r;
  logic                alt_r;
  logic [4:0]          rd_r;
  logic                we_r;
  logic                illegal_r;
  logic [CNT_W-1:0]    cnt_r;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign rd_s     = instr[11:7];
  assign imm_i_s  = DATA_W'($signed(instr[31:20]));
  assign imm_u_s  = DATA_W'($signed({instr[31:12], 12'b0000_0000_0000}));

  // Flush blocks acceptance so a killed cycle never loads or counts.
  assign in_ready = !flush && (!valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  // Combinational instruction decode into ALU operands and control.
  always_comb begin
    src_a_s   = {DATA_W{1'b0}};
    src_b_s   = {DATA_W{1'b0}};
    op_s      = 3'b000;
    alt_s     = 1'b0;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        src_a_s = rs1_val;
        src_b_s = rs2_val;
        op_s    = funct3_s;
        alt_s   = instr[30];
        if (funct7_s == F7_BASE) begin
          illegal_s = 1'b0;
        end else if (funct7_s == F7_ALT) begin
          illegal_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        src_a_s = rs1_val;
        src_b_s = imm_i_s;
        op_s    = funct3_s;
        alt_s   = (funct3_s == 3'b101) ? instr[30] : 1'b0;
        case (funct3_s)
          3'b001:  illegal_s = (funct7_s != F7_BASE);
          3'b101:  illegal_s = !((funct7_s == F7_BASE) || (funct7_s == F7_ALT));
          default: illegal_s = 1'b0;
        endcase
      end
      OPC_LUI: begin
        src_b_s = imm_u_s;
      end
      OPC_AUIPC: begin
        src_a_s = pc;
        src_b_s = imm_u_s;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    we_s = !illegal_s && (rd_s != 5'd0);
  end

  // Output entry valid flag: flush wins, then a new accept, then consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  // Entry payload loads only on accept, so it stays frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_r   <= {DATA_W{1'b0}};
      src_b_r   <= {DATA_W{1'b0}};
      op_r      <= {ALU_OP_W{1'b0}};
      alt_r     <= 1'b0;
      rd_r      <= 5'd0;
      we_r      <= 1'b0;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      src_a_r   <= src_a_s;
      src_b_r   <= src_b_s;
      op_r      <= ALU_OP_W'(op_s);
      alt_r     <= alt_s;
      rd_r      <= rd_s;
      we_r      <= we_s;
      illegal_r <= illegal_s;
    end
  end

  // Accepted-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign out_valid   = valid_r;
  assign out_src_a   = src_a_r;
  assign out_src_b   = src_b_r;
  assign out_op      = op_r;
  assign out_alt     = alt_r;
  assign out_rd      = rd_r;
  assign out_we      = we_r;
  assign out_illegal = illegal_r;
  assign dec_cnt     = cnt_r;

endmodule

// File: tb/tb_alu_dec_stage.sv
// Directed-vector bench for alu_dec_stage; counter width reduced to 4 so the
// wrap can be reached quickly.
module tb_alu_dec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src_a;
  logic [31:0] out_src_b;
  logic [2:0]  out_op;
  logic        out_alt;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic [3:0]  dec_cnt;

  int n_vec = 0;
  int n_err = 0;

  alu_dec_stage #(.DATA_W(32), .ALU_OP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_op(out_op),
    .out_alt(out_alt), .out_rd(out_rd), .out_we(out_we),
    .out_illegal(out_illegal), .dec_cnt(dec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p);
    instr    = i;
    rs1_val  = a;
    rs2_val  = b;
    pc       = p;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic check_entry(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic alt, input logic [4:0] rd,
                             input logic we, input logic ill);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".src_a"}, out_src_a, a);
    check_eq({tag, ".src_b"}, out_src_b, b);
    check_eq({tag, ".op"}, 32'(out_op), 32'(op));
    check_eq({tag, ".alt"}, 32'(out_alt), 32'(alt));
    check_eq({tag, ".rd"}, 32'(out_rd), 32'(rd));
    check_eq({tag, ".we"}, 32'(out_we), 32'(we));
    check_eq({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0000_0000;
    pc        = 32'h0000_0000;
    rs1_val   = 32'h0000_0000;
    rs2_val   = 32'h0000_0000;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.cnt", 32'(dec_cnt), 32'd0);
    check_eq("rst.src_a", out_src_a, 32'd0);
    check_eq("rst.we", 32'(out_we), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rel.in_ready", 32'(in_ready), 32'd1);

    // ADD x3,x1,x2
    offer(32'h0020_81B3, 32'd5, 32'd7, 32'h0000_1000);
    check_entry("add", 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0);
    check_eq("add.cnt", 32'(dec_cnt), 32'd1);

    // SUB then SRAI back to back
    offer(32'h4020_81B3, 32'd9, 32'd4, 32'h0000_1004);
    check_entry("sub", 32'd9, 32'd4, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0);
    check_eq("sub.cnt", 32'(dec_cnt), 32'd2);
    offer(32'h4043_5293, 32'h8000_0000, 32'd0, 32'h0000_1008);
    check_entry("srai", 32'h8000_0000, 32'h0000_0404, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0);
    check_eq("srai.cnt", 32'(dec_cnt), 32'd3);

    // Immediates
    offer(32'hFFF0_0093, 32'd0, 32'd0, 32'h0000_100C);
    check_entry("addi_m1", 32'd0, 32'hFFFF_FFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0);
    offer(32'h1234_53B7, 32'hDEAD_BEEF, 32'd0, 32'h0000_1010);
    check_entry("lui", 32'd0, 32'h1234_5000, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0);
    offer(32'h0010_0013, 32'd0, 32'd0, 32'h0000_1014);
    check_entry("addi_x0", 32'd0, 32'd1, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
    offer(32'h0000_1117, 32'd0, 32'd0, 32'h0000_2000);
    check_entry("auipc", 32'h0000_2000, 32'h0000_1000, 3'b000, 1'b0, 5'd2, 1'b1, 1'b0);
    check_eq("auipc.cnt", 32'(dec_cnt), 32'd7);

    // Backpressure: XOR x8,x5,x6 offered while execute stalls
    out_ready = 1'b0;
    instr     = 32'h0062_C433;
    rs1_val   = 32'h0000_00F0;
    rs2_val   = 32'h0000_000F;
    pc        = 32'h0000_2004;
    #1;
    check_eq("stall.in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall.in_ready", 32'(in_ready), 32'd0);
      check_eq("stall.rd", 32'(out_rd), 32'd2);
      check_eq("stall.src_a", out_src_a, 32'h0000_2000);
      check_eq("stall.cnt", 32'(dec_cnt), 32'd7);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_entry("xor", 32'h0000_00F0, 32'h0000_000F, 3'b100, 1'b0, 5'd8, 1'b1, 1'b0);
    check_eq("xor.cnt", 32'(dec_cnt), 32'd8);

    // Flush kills the held entry and the offer
    flush = 1'b1;
    instr = 32'h0020_81B3;
    #1;
    check_eq("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("flush.valid", 32'(out_valid), 32'd0);
    check_eq("flush.cnt", 32'(dec_cnt), 32'd8);
    flush = 1'b0;

    // Illegal encodings still traverse the handshake
    offer(32'h0000_007F, 32'd1, 32'd2, 32'h0000_3000);
    check_eq("ill_opc.valid", 32'(out_valid), 32'd1);
    check_eq("ill_opc.illegal", 32'(out_illegal), 32'd1);
    check_eq("ill_opc.we", 32'(out_we), 32'd0);
    check_eq("ill_opc.cnt", 32'(dec_cnt), 32'd9);
    offer(32'h0220_81B3, 32'd1, 32'd2, 32'h0000_3004);
    check_eq("ill_f7.illegal", 32'(out_illegal), 32'd1);
    check_eq("ill_f7.we", 32'(out_we), 32'd0);
    offer(32'h4020_9093, 32'd1, 32'd2, 32'h0000_3008);
    check_eq("ill_slli.illegal", 32'(out_illegal), 32'd1);
    check_eq("ill_slli.rd", 32'(out_rd), 32'd1);
    check_eq("ill.cnt", 32'(dec_cnt), 32'd11);

    // Reset mid-stall drops outputs before the next edge
    in_valid  = 1'b0;
    out_ready = 1'b0;
    offer(32'h0020_81B3, 32'd5, 32'd7, 32'h0000_300C);
    in_valid = 1'b0;
    tick();
    check_eq("pre_rst.valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst.valid", 32'(out_valid), 32'd0);
    check_eq("async_rst.cnt", 32'(dec_cnt), 32'd0);
    check_eq("async_rst.src_b", out_src_b, 32'd0);
    check_eq("async_rst.rd", 32'(out_rd), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // First accept after reset, then wrap at 17 accepts
    offer(32'h0010_0093, 32'd0, 32'd0, 32'h0000_4000);
    check_eq("post_rst.cnt", 32'(dec_cnt), 32'd1);
    for (int k = 1; k < 17; k++) begin
      offer(32'h0010_0093, 32'd0, 32'd0, 32'h0000_4000);
    end
    check_eq("wrap.cnt", 32'(dec_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    check_eq("drain.valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
